// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   N-master to 1-slave arbiter for the req/gnt bus. One transfer at a time is
//   granted to a single owner chosen round-robin; the slave's completion pulse
//   and read data are routed back to that owner only.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : a slave that stays silent for TIMEOUT_CYC BUSY cycles gets the
//               transfer completed on its behalf with m_rdata = 32'hDEAD_BEEF
//               (sized to DATA_W) and an o_m_err pulse.
//   Undefined : no wait counter, no o_m_err port; a silent slave holds the bus.
//
// Ports
//   i_clk       bus clock, rising edge
//   i_rst       synchronous active-high reset
//   i_m_req     per-master request
//   i_m_addr    packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   i_m_wdata   packed master write data, master i at [i*DATA_W +: DATA_W]
//   i_m_wr_en   per-master write enable (1=write, 0=read)
//   o_m_gnt     one-hot completion pulse to the owner
//   o_m_rdata   shared read data, non-zero only alongside an o_m_gnt pulse
//   o_m_err     (BUS_TIMEOUT_EN only) timeout completion pulse
//   o_s_req     request to slave (high for the whole BUSY state)
//   o_s_addr    owner's address
//   o_s_wdata   owner's write data
//   o_s_wr_en   owner's write enable
//   i_s_gnt     slave completion pulse
//   i_s_rdata   slave read data, valid with i_s_gnt
//   o_busy      transfer in progress
//   o_owner     current owner while BUSY, last owner while IDLE
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    localparam int OWNER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_MASTERS-1:0]        i_m_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_m_wdata,
    input  logic [NUM_MASTERS-1:0]        i_m_wr_en,
    output logic [NUM_MASTERS-1:0]        o_m_gnt,
    output logic [DATA_W-1:0]             o_m_rdata,
`ifdef BUS_TIMEOUT_EN
    output logic                          o_m_err,
`endif
    output logic                          o_s_req,
    output logic [ADDR_W-1:0]             o_s_addr,
    output logic [DATA_W-1:0]             o_s_wdata,
    output logic                          o_s_wr_en,
    input  logic                          i_s_gnt,
    input  logic [DATA_W-1:0]             i_s_rdata,
    output logic                          o_busy,
    output logic [OWNER_W-1:0]            o_owner
);

    // Reject parameter sets the arbitration arithmetic is not sized for.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("bus_rr_arbiter: unsupported parameter set");
    end

    // One extra bit so (owner + offset) can exceed NUM_MASTERS before wrapping.
    localparam int SUM_W = OWNER_W + 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OWNER_W-1:0]   r_owner;      // doubles as the round-robin pointer

    logic [ADDR_W-1:0]    w_addr  [NUM_MASTERS];
    logic [DATA_W-1:0]    w_wdata [NUM_MASTERS];

    logic                 w_found;
    logic [OWNER_W-1:0]   w_winner;
    logic [SUM_W-1:0]     w_sum;

    logic                 w_in_busy;
    logic                 w_owner_req;
    logic                 w_done;
    logic                 w_timeout;

    // Unpack the flat master buses so the owner can select with a plain index.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_addr[gi]  = i_m_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata[gi] = i_m_wdata[gi*DATA_W +: DATA_W];
    end

    // Round-robin search: scan offsets 1..N from the last owner, so the last
    // owner itself is considered only after everyone else.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        w_sum    = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_sum = {1'b0, r_owner} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_MASTERS))
                w_sum = w_sum - SUM_W'(NUM_MASTERS);
            if (!w_found && i_m_req[w_sum[OWNER_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[OWNER_W-1:0];
            end
        end
    end

    assign w_in_busy   = (r_state == S_BUSY);
    assign w_owner_req = i_m_req[r_owner];
    // A reset cycle must not complete the transfer it is tearing down.
    assign w_done      = w_in_busy & i_s_gnt & ~i_rst;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [TW-1:0] r_wait;

    // The counter holds (BUSY cycle number - 1), so the match fires on the
    // TIMEOUT_CYC-th BUSY cycle. An owner that has already walked away is
    // treated as an abandon rather than handed a timeout completion.
    assign w_timeout = w_in_busy & ~i_s_gnt & w_owner_req & ~i_rst &
                       (r_wait == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == S_IDLE)
            r_wait <= '0;
        else
            r_wait <= r_wait + 1'b1;
    end

    assign o_m_err = w_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    // State and owner/pointer register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_owner <= OWNER_W'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found)
                r_owner <= w_winner;
        end
    end

    // Next state and bus outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_s_req     = 1'b0;
        o_s_addr    = '0;
        o_s_wdata   = '0;
        o_s_wr_en   = 1'b0;
        o_m_gnt     = '0;
        o_m_rdata   = '0;

        case (r_state)
            S_IDLE: begin
                if (w_found)
                    w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                o_s_req   = 1'b1;
                o_s_addr  = w_addr[r_owner];
                o_s_wdata = w_wdata[r_owner];
                o_s_wr_en = i_m_wr_en[r_owner];
                // Completion has priority over an abandon in the same cycle.
                if (i_s_gnt || !w_owner_req || w_timeout)
                    w_state_nxt = S_IDLE;
                if (w_done || w_timeout)
                    o_m_gnt = NUM_MASTERS'(1) << r_owner;
                if (w_done)
                    o_m_rdata = i_s_rdata;
`ifdef BUS_TIMEOUT_EN
                else if (w_timeout)
                    o_m_rdata = TIMEOUT_DATA;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy  = w_in_busy;
    assign o_owner = r_owner;

endmodule
